alux_sequencer: RTL and testbench
=================================

Name: alux_sequencer

Overview:
- Sequences one micro-instruction at a time through the register bank and the ALUX.
- Per instruction: reads two source registers, starts the ALUX, waits for `done`, then writes the ALUX result back to a destination register.
- Sits between an instruction source (valid/ready handshake) and the `reg_bank` / `ALUX` pair, and replaces direct testbench sequencing of those blocks.
- A watchdog aborts instructions whose ALUX `done` never arrives.

Parameters:
- DATA_W, 64, datapath width (ALUX result, write-back data).
- RADDR_W, 4, register address width (16 registers).
- TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before abort; legal range 2..65535.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 forces reset immediately.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_opr  in  4  ALUX operation code.
- instr_srca  in  RADDR_W  source register A.
- instr_srcb  in  RADDR_W  source register B.
- instr_dst  in  RADDR_W  destination register.
- instr_wb  in  1  1 = write the result back to instr_dst.
- instr_cnst  in  2  bit0 drives cnstA, bit1 drives cnstB during the operand read.
- seloutA, seloutB  out  RADDR_W  reg_bank read selects.
- enrregA, enrregB  out  1  reg_bank output-register enables.
- cnstA, cnstB  out  1  reg_bank constant selects.
- regwen  out  1  reg_bank write enable.
- selwreg  out  RADDR_W  reg_bank write address.
- endwreg  out  2  reg_bank write mode; constant 2'b00.
- wdata  out  DATA_W  reg_bank write data.
- opr  out  4  ALUX operation.
- start  out  1  ALUX start pulse.
- done  in  1  ALUX completion.
- alux_result  in  DATA_W  ALUX outAB.
- result  out  DATA_W  last completed result.
- result_valid  out  1  one-cycle pulse when `result` is updated.
- busy  out  1  1 in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE.
  - All outputs 0, except instr_ready=1 and endwreg=2'b00.
  - Watchdog counter cleared; captured instruction fields cleared.
- Reset asserted mid-instruction: the instruction is abandoned.
  - No regwen is issued.
  - No result_valid or timeout_err is issued.
- State machine: IDLE -> READ -> LATCH -> START -> WAIT -> WB -> IDLE.
  - Encoding lives in the package.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready at a rising edge: capture all instr_* fields and go to READ.
  - instr_ready=0 in every other state; instruction fields presented then are ignored.
- READ (1 cycle):
  - seloutA=srca, seloutB=srcb, cnstA/cnstB from cnst, enrregA=enrregB=1.
  - opr = captured opcode; opr is held from READ through WB.
- LATCH (1 cycle):
  - Selects held, enrregA/B=0, so reg_bank outputs are stable for the ALUX.
- START (1 cycle):
  - start=1 for exactly this cycle.
  - Watchdog loads TIMEOUT_CYCLES.
- WAIT:
  - start=0.
  - Each cycle, if done=1: capture alux_result into the result register and go to WB.
  - Otherwise decrement the watchdog. When it reaches 0 without done: pulse timeout_err for 1 cycle, no write-back, return to IDLE.
  - done=1 in the same cycle the counter expires counts as success; done has priority.
- WB (1 cycle):
  - result_valid=1.
  - If wb=1: regwen=1, selwreg=dst, wdata=result.
  - If wb=0: regwen=0, selwreg and wdata hold their previous values.
- Next-instruction timing: IDLE is re-entered the following cycle, so a new instruction can be accepted one cycle after WB.
- done asserted outside WAIT is ignored.
- Latency: the accept edge is T0.
  - READ occupies cycle T1, LATCH T2, START T3.
  - If ALUX asserts done in the k-th WAIT cycle (k≥1), WB occupies cycle T3+k+1.
  - Minimum accept-to-accept interval is therefore 6 cycles.
- Register usage:
  - srca==srcb is legal.
  - dst may equal a source; the write happens after the ALUX has consumed the operands.
- result holds its value until the next successful completion; it is not cleared on timeout.
- All outputs are registered, with no combinational path from done to regwen.

Decomposition:
- Package alux_pkg:
  - Opcode constants: OPR_A=4'b0000, OPR_B=4'b0001, OPR_ADD=4'b0010, OPR_SUB=4'b0011.
  - Sequencer state encoding.
  - ENDW_DEFAULT=2'b00.
- One sub-module, alux_watchdog: loadable down-counter with load, decrement-enable and an expired flag; parameterised by TIMEOUT_CYCLES.

Test Plan:
- ADD write-back:
  - Stimulus: preload R1=0x0000_0000_0000_0005 and R2=0x0000_0000_0000_0003 via reg_bank; issue opr=0010, srca=1, srcb=2, dst=3, wb=1.
  - Expected: start pulses exactly 1 cycle at T3; after done, regwen=1 with selwreg=3, wdata=0x8; result_valid pulses once.
- SUB with dst==srca:
  - Stimulus: R4=0x10, R5=0x1; opr=0011, srca=4, srcb=5, dst=4.
  - Expected: R4 becomes 0xF afterwards.
- wb=0:
  - Stimulus: opr=0000, srca=7, wb=0.
  - Expected: result=R7 and result_valid pulses; regwen stays 0 throughout.
- Timeout:
  - Stimulus: ALUX stubbed so done never rises; TIMEOUT_CYCLES=8.
  - Expected: timeout_err pulses exactly 8 cycles after the START cycle; no regwen; instr_ready=1 on the next cycle.
- Back-to-back:
  - Stimulus: instr_valid held high for 3 instructions.
  - Expected: each is accepted only when instr_ready=1; exactly 3 WB cycles occur, in order.
- Reset in WAIT:
  - Stimulus: drive reset=0 asynchronously (mid-cycle) while in WAIT.
  - Expected: busy=0 and start=0 immediately; no regwen or result_valid afterwards; instr_ready=1 after release.

Source files
------------

// File: rtl/alux_pkg.sv
// rtl/alux_pkg.sv - shared opcodes, write-mode default and sequencer state encoding
package alux_pkg;

  localparam logic [3:0] OPR_A   = 4'b0000;
  localparam logic [3:0] OPR_B   = 4'b0001;
  localparam logic [3:0] OPR_ADD = 4'b0010;
  localparam logic [3:0] OPR_SUB = 4'b0011;

  localparam logic [1:0] ENDW_DEFAULT = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_WB    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/alux_watchdog.sv
// rtl/alux_watchdog.sv - loadable down-counter that flags the last cycle before it reaches zero
module alux_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(TIMEOUT_CYCLES);
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // High while the pending decrement is the one that brings the count to zero
  assign expired = (count == CNT_W'(1));

endmodule

// File: rtl/alux_sequencer.sv
// rtl/alux_sequencer.sv - runs one micro-instruction through reg_bank and ALUX with a done watchdog
module alux_sequencer
  import alux_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int RADDR_W        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [3:0]         instr_opr,
  input  logic [RADDR_W-1:0] instr_srca,
  input  logic [RADDR_W-1:0] instr_srcb,
  input  logic [RADDR_W-1:0] instr_dst,
  input  logic               instr_wb,
  input  logic [1:0]         instr_cnst,
  output logic [RADDR_W-1:0] seloutA,
  output logic [RADDR_W-1:0] seloutB,
  output logic               enrregA,
  output logic               enrregB,
  output logic               cnstA,
  output logic               cnstB,
  output logic               regwen,
  output logic [RADDR_W-1:0] selwreg,
  output logic [1:0]         endwreg,
  output logic [DATA_W-1:0]  wdata,
  output logic [3:0]         opr,
  output logic               start,
  input  logic               done,
  input  logic [DATA_W-1:0]  alux_result,
  output logic [DATA_W-1:0]  result,
  output logic               result_valid,
  output logic               busy,
  output logic               timeout_err
);

  seq_state_t         state;
  logic [RADDR_W-1:0] dst_q;
  logic               wb_q;
  logic               wd_load;
  logic               wd_dec;
  logic               wd_expired;

  // START is counted as the first watchdog cycle, so WAIT lasts at most TIMEOUT_CYCLES-1 cycles
  assign wd_load = (state == ST_LATCH);
  assign wd_dec  = (state == ST_START) || ((state == ST_WAIT) && !done);

  alux_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .load   (wd_load),
    .dec    (wd_dec),
    .expired(wd_expired)
  );

  assign endwreg = ENDW_DEFAULT;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      instr_ready  <= 1'b1;
      busy         <= 1'b0;
      seloutA      <= '0;
      seloutB      <= '0;
      enrregA      <= 1'b0;
      enrregB      <= 1'b0;
      cnstA        <= 1'b0;
      cnstB        <= 1'b0;
      opr          <= '0;
      start        <= 1'b0;
      regwen       <= 1'b0;
      selwreg      <= '0;
      wdata        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      dst_q        <= '0;
      wb_q         <= 1'b0;
    end else begin
      start        <= 1'b0;
      regwen       <= 1'b0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid && instr_ready) begin
            seloutA     <= instr_srca;
            seloutB     <= instr_srcb;
            cnstA       <= instr_cnst[0];
            cnstB       <= instr_cnst[1];
            enrregA     <= 1'b1;
            enrregB     <= 1'b1;
            opr         <= instr_opr;
            dst_q       <= instr_dst;
            wb_q        <= instr_wb;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_READ;
          end
        end
        ST_READ: begin
          enrregA <= 1'b0;
          enrregB <= 1'b0;
          state   <= ST_LATCH;
        end
        ST_LATCH: begin
          start <= 1'b1;
          state <= ST_START;
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // done wins over an expiring watchdog in the same cycle
          if (done) begin
            result       <= alux_result;
            result_valid <= 1'b1;
            if (wb_q) begin
              regwen  <= 1'b1;
              selwreg <= dst_q;
              wdata   <= alux_result;
            end
            state <= ST_WB;
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_WB: begin
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alux_sequencer.sv
// tb/tb_alux_sequencer.sv - directed and randomized checks of alux_sequencer against a behavioural reg_bank/ALUX model
module tb_alux_sequencer;
  import alux_pkg::*;

  localparam int DATA_W  = 64;
  localparam int RADDR_W = 4;
  localparam int TO      = 8;
  localparam logic [63:0] CONST_VAL = 64'd1;

  logic               clock = 1'b0;
  logic               reset;
  logic               instr_valid;
  logic               instr_ready;
  logic [3:0]         instr_opr;
  logic [RADDR_W-1:0] instr_srca, instr_srcb, instr_dst;
  logic               instr_wb;
  logic [1:0]         instr_cnst;
  logic [RADDR_W-1:0] seloutA, seloutB, selwreg;
  logic               enrregA, enrregB, cnstA, cnstB, regwen;
  logic [1:0]         endwreg;
  logic [DATA_W-1:0]  wdata, alux_result, result;
  logic [3:0]         opr;
  logic               start, done, result_valid, busy, timeout_err;

  always #5 clock = ~clock;

  alux_sequencer #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opr(instr_opr),
    .instr_srca(instr_srca), .instr_srcb(instr_srcb), .instr_dst(instr_dst),
    .instr_wb(instr_wb), .instr_cnst(instr_cnst),
    .seloutA(seloutA), .seloutB(seloutB), .enrregA(enrregA), .enrregB(enrregB),
    .cnstA(cnstA), .cnstB(cnstB), .regwen(regwen), .selwreg(selwreg), .endwreg(endwreg),
    .wdata(wdata), .opr(opr), .start(start), .done(done), .alux_result(alux_result),
    .result(result), .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] regs [16];
  logic [63:0] ref_regs [16];
  logic [63:0] opa, opb, last_res;
  logic [3:0]  op_l;
  bit          pend, dead;
  int          cnt, delay_set;
  int          t, starts, wens, rvs, tos;

  function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      OPR_A:   return a;
      OPR_B:   return b;
      OPR_ADD: return a + b;
      OPR_SUB: return a - b;
      default: return 64'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: the reg_bank/ALUX model reacts to what the DUT presents this cycle, then the edge passes
  task automatic step();
    if (enrregA) opa = cnstA ? CONST_VAL : regs[seloutA];
    if (enrregB) opb = cnstB ? CONST_VAL : regs[seloutB];
    if (regwen) regs[selwreg] = wdata;
    if (start) begin pend = 1; cnt = delay_set; op_l = opr; end
    starts += int'(start);
    wens   += int'(regwen);
    rvs    += int'(result_valid);
    tos    += int'(timeout_err);
    @(posedge clock);
    #1;
    t++;
    done = 1'b0;
    alux_result = {$urandom, $urandom};
    if (pend && !dead) begin
      cnt--;
      if (cnt == 0) begin
        done = 1'b1;
        alux_result = alu_ref(op_l, opa, opb);
        pend = 0;
      end
    end
  endtask

  // dly = WAIT cycle in which done rises; 0 means done never rises
  task automatic run(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                     input logic w, input logic [1:0] c, input int dly, input bit hold);
    logic [63:0] va, vb, er;
    int budget;
    va = c[0] ? CONST_VAL : ref_regs[a];
    vb = c[1] ? CONST_VAL : ref_regs[b];
    er = alu_ref(op, va, vb);
    delay_set = dly;
    dead = (dly == 0);
    instr_opr = op; instr_srca = a; instr_srcb = b; instr_dst = d; instr_wb = w; instr_cnst = c;
    instr_valid = 1'b1;
    budget = 0;
    while (!instr_ready && budget < 20) begin step(); budget++; end
    check("accept_ready", 64'(instr_ready), 64'd1);
    if (hold) check("b2b_no_stall", 64'(budget), 64'd0);
    starts = 0; wens = 0; rvs = 0; tos = 0; t = 0;
    step();
    if (!hold) instr_valid = 1'b0;
    instr_opr = 4'($urandom); instr_srca = 4'($urandom); instr_srcb = 4'($urandom);
    instr_dst = 4'($urandom); instr_wb = 1'($urandom); instr_cnst = 2'($urandom);
    check("t1_seloutA", 64'(seloutA), 64'(a));
    check("t1_seloutB", 64'(seloutB), 64'(b));
    check("t1_enrreg", 64'({enrregA, enrregB}), 64'd3);
    check("t1_cnst", 64'({cnstB, cnstA}), 64'(c));
    check("t1_opr", 64'(opr), 64'(op));
    check("t1_busy_ready", 64'({busy, instr_ready}), 64'b10);
    step();
    check("t2_enrreg", 64'({enrregA, enrregB}), 64'd0);
    check("t2_sel_held", 64'({seloutA, seloutB}), 64'({a, b}));
    step();
    check("t3_start", 64'(start), 64'd1);
    step();
    check("t4_start_low", 64'(start), 64'd0);
    while (!result_valid && !timeout_err && t < 40) step();
    if (dly == 0) begin
      check("to_cycle", 64'(t), 64'(3 + TO));
      check("to_pulse", 64'(timeout_err), 64'd1);
      check("to_ready", 64'(instr_ready), 64'd1);
      check("to_result_kept", result, last_res);
    end else begin
      check("wb_cycle", 64'(t), 64'(3 + dly + 1));
      check("wb_result", result, er);
      check("wb_regwen", 64'(regwen), 64'(w));
      if (w) begin
        check("wb_selwreg", 64'(selwreg), 64'(d));
        check("wb_wdata", wdata, er);
        ref_regs[d] = er;
      end
      check("wb_opr_held", 64'(opr), 64'(op));
      last_res = er;
    end
    check("start_once", 64'(starts), 64'd1);
    step();
    check("after_pulses", 64'({result_valid, timeout_err}), 64'd0);
    check("after_idle", 64'({instr_ready, busy}), 64'b10);
    check("regwen_count", 64'(wens), (dly == 0) ? 64'd0 : 64'(w));
    check("rv_count", 64'(rvs), (dly == 0) ? 64'd0 : 64'd1);
    check("to_count", 64'(tos), (dly == 0) ? 64'd1 : 64'd0);
    dead = 0; pend = 0;
  endtask

  initial begin
    instr_valid = 0; instr_opr = 0; instr_srca = 0; instr_srcb = 0; instr_dst = 0;
    instr_wb = 0; instr_cnst = 0; done = 0; alux_result = 0;
    pend = 0; dead = 0; cnt = 0; delay_set = 1; last_res = 0; opa = 0; opb = 0; op_l = 0;
    t = 0; starts = 0; wens = 0; rvs = 0; tos = 0;
    for (int i = 0; i < 16; i++) begin
      regs[i] = {$urandom, $urandom};
      ref_regs[i] = regs[i];
    end
    regs[1] = 64'h5; regs[2] = 64'h3; regs[4] = 64'h10; regs[5] = 64'h1;
    ref_regs[1] = 64'h5; ref_regs[2] = 64'h3; ref_regs[4] = 64'h10; ref_regs[5] = 64'h1;

    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_ready_busy", 64'({instr_ready, busy}), 64'b10);
    check("rst_endwreg", 64'(endwreg), 64'd0);
    check("rst_pulses", 64'({start, regwen, result_valid, timeout_err, enrregA, enrregB}), 64'd0);
    check("rst_result", result, 64'd0);
    step(); step();
    reset = 1'b1;
    step();

    run(OPR_ADD, 4'd1, 4'd2, 4'd3, 1'b1, 2'b00, 1, 1'b0);
    check("add_r3", regs[3], 64'h8);
    run(OPR_SUB, 4'd4, 4'd5, 4'd4, 1'b1, 2'b00, 2, 1'b0);
    check("sub_r4", regs[4], 64'hF);
    run(OPR_A, 4'd7, 4'd0, 4'd9, 1'b0, 2'b00, 3, 1'b0);
    check("wb0_result_r7", result, regs[7]);
    run(OPR_ADD, 4'd1, 4'd2, 4'd6, 1'b1, 2'b00, TO - 1, 1'b0);
    run(OPR_ADD, 4'd3, 4'd3, 4'd8, 1'b1, 2'b11, 2, 1'b0);
    check("cnst_r8", regs[8], 64'h2);
    run(OPR_SUB, 4'd1, 4'd2, 4'd10, 1'b1, 2'b00, 0, 1'b0);

    run(OPR_ADD, 4'd11, 4'd12, 4'd13, 1'b1, 2'b00, 1, 1'b1);
    run(OPR_SUB, 4'd13, 4'd1, 4'd14, 1'b1, 2'b00, $urandom_range(1, 4), 1'b1);
    run(OPR_B, 4'd0, 4'd14, 4'd15, 1'b1, 2'b00, $urandom_range(1, 4), 1'b0);

    done = 1'b1;
    alux_result = 64'hDEAD;
    step();
    check("idle_done_ignored", 64'({busy, result_valid, regwen}), 64'd0);

    for (int n = 0; n < 12; n++) begin
      run(4'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom),
          1'($urandom), 2'($urandom), $urandom_range(1, TO - 1), 1'b0);
    end

    instr_opr = OPR_ADD; instr_srca = 4'd1; instr_srcb = 4'd2; instr_dst = 4'd0;
    instr_wb = 1'b1; instr_cnst = 2'b00; instr_valid = 1'b1; dead = 1;
    step();
    instr_valid = 1'b0;
    step(); step(); step();
    check("rw_in_wait", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rw_async", 64'({busy, start, regwen, instr_ready}), 64'b0001);
    wens = 0; rvs = 0; tos = 0;
    step(); step();
    reset = 1'b1;
    dead = 0; pend = 0; last_res = 0;
    for (int i = 0; i < 6; i++) step();
    check("rw_no_side_effects", 64'({wens[7:0], rvs[7:0], tos[7:0]}), 64'd0);
    check("rw_ready_after", 64'({instr_ready, busy}), 64'b10);
    check("rw_result_cleared", result, 64'd0);

    for (int i = 0; i < 16; i++) check($sformatf("final_r%0d", i), regs[i], ref_regs[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
